// File: rtl/wallace_pkg.sv
// Shared constants and helpers for the pipelined Wallace-tree multiplier.
// The row-pair struct is declared inside each module so it can follow WIDTH.
package wallace_pkg;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 32;

  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/wallace_reduce_tree.sv
// Combinational partial-product generation (AND array or Baugh-Wooley) and
// Wallace reduction of those rows to a redundant sum/carry pair.
module wallace_reduce_tree
  import wallace_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic [2*WIDTH-1:0] sum,
  output logic [2*WIDTH-1:0] carry
);

  localparam int PW  = prod_w(WIDTH);
  localparam int NPP = WIDTH + 1;

  function automatic int next_rows(input int n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int rows_at(input int lvl);
    int n;
    n = NPP;
    for (int k = 0; k < lvl; k++) n = next_rows(n);
    return n;
  endfunction

  function automatic int count_levels(input int n0);
    int n;
    int l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = next_rows(n);
      l++;
    end
    return l;
  endfunction

  localparam int LEVELS = count_levels(NPP);

  logic [PW-1:0] pp [NPP];

  // Signed mode inverts the cross terms that touch exactly one sign bit and
  // adds the constant correction 2^WIDTH + 2^(2*WIDTH-1) as an extra row.
  always_comb begin
    for (int j = 0; j < NPP; j++) pp[j] = '0;
    for (int j = 0; j < WIDTH; j++) begin
      for (int i = 0; i < WIDTH; i++) begin
        pp[j][i+j] = (a[i] & b[j]) ^ (is_signed & ((i == WIDTH-1) != (j == WIDTH-1)));
      end
    end
    pp[WIDTH][WIDTH] = is_signed;
    pp[WIDTH][PW-1]  = is_signed;
  end

  for (genvar l = 0; l < LEVELS; l++) begin : lvl
    localparam int NIN  = rows_at(l);
    localparam int NOUT = rows_at(l + 1);
    localparam int NGRP = NIN / 3;

    logic [PW-1:0] din  [NIN];
    logic [PW-1:0] dout [NOUT];

    if (l == 0) begin : g_src
      for (genvar g = 0; g < NIN; g++) begin : g_row
        assign din[g] = pp[g];
      end
    end else begin : g_src
      for (genvar g = 0; g < NIN; g++) begin : g_row
        assign din[g] = lvl[l-1].dout[g];
      end
    end

    // Each group of three rows becomes one sum row and one carry row;
    // bits shifted past the product width are discarded modulo 2^PW.
    for (genvar g = 0; g < NGRP; g++) begin : g_csa
      logic [PW-1:0] x, y, z;
      assign x = din[3*g];
      assign y = din[3*g+1];
      assign z = din[3*g+2];
      assign dout[2*g]   = x ^ y ^ z;
      assign dout[2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
    end

    for (genvar g = 0; g < NIN % 3; g++) begin : g_pass
      assign dout[2*NGRP+g] = din[3*NGRP+g];
    end
  end

  assign sum   = lvl[LEVELS-1].dout[0];
  assign carry = lvl[LEVELS-1].dout[1];

endmodule

// File: rtl/wallace_mult_pipe.sv
// Pipelined WIDTH x WIDTH signed/unsigned multiplier with valid/ready handshakes
// and bubble-collapsing stages: [S0 operands] -> S1 sum/carry rows -> S2 product.
module wallace_mult_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int PW = prod_w(WIDTH);

  typedef struct packed {
    logic [PW-1:0] sum;
    logic [PW-1:0] carry;
  } rows_t;

  if (STAGES != 2 && STAGES != 3) begin : g_bad_stages
    $fatal(1, "wallace_mult_pipe: STAGES must be 2 or 3");
  end

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $fatal(1, "wallace_mult_pipe: WIDTH out of range 4..32");
  end

  logic             accept_en;
  logic             tree_valid;
  logic [WIDTH-1:0] tree_a;
  logic [WIDTH-1:0] tree_b;
  logic             tree_signed;
  logic [PW-1:0]    tree_sum;
  logic [PW-1:0]    tree_carry;
  rows_t            rows_d;
  rows_t            rows_q;
  logic             v1;
  logic             v2;
  logic [PW-1:0]    res_q;
  logic             ld1;
  logic             ld2;
  logic             out_fire;

  // Each stage loads when it is empty or its successor is moving, so
  // bubbles collapse even while the output is back-pressured.
  assign out_fire = v2 && out_ready;
  assign ld2      = !v2 || out_fire;
  assign ld1      = !v1 || ld2;

  // Holds off acceptance until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) accept_en <= 1'b0;
    else        accept_en <= 1'b1;
  end

  if (STAGES == 3) begin : g_s0
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             s0_signed;
    logic             v0;
    logic             ld0;

    assign ld0      = !v0 || ld1;
    assign in_ready = accept_en && ld0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v0        <= 1'b0;
        a0        <= '0;
        b0        <= '0;
        s0_signed <= 1'b0;
      end else if (ld0) begin
        v0        <= in_valid && in_ready;
        a0        <= a;
        b0        <= b;
        s0_signed <= is_signed;
      end
    end

    assign tree_a      = a0;
    assign tree_b      = b0;
    assign tree_signed = s0_signed;
    assign tree_valid  = v0;
  end else begin : g_no_s0
    assign in_ready    = accept_en && ld1;
    assign tree_a      = a;
    assign tree_b      = b;
    assign tree_signed = is_signed;
    assign tree_valid  = in_valid && in_ready;
  end

  wallace_reduce_tree #(
    .WIDTH(WIDTH)
  ) u_tree (
    .a         (tree_a),
    .b         (tree_b),
    .is_signed (tree_signed),
    .sum       (tree_sum),
    .carry     (tree_carry)
  );

  assign rows_d = '{sum: tree_sum, carry: tree_carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      rows_q <= '0;
    end else if (ld1) begin
      v1     <= tree_valid;
      rows_q <= rows_d;
    end
  end

  // Final carry-propagate add of the redundant rows into the product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      res_q <= '0;
    end else if (ld2) begin
      v2    <= v1;
      res_q <= rows_q.sum + rows_q.carry;
    end
  end

  assign out_valid = v2;
  assign result    = res_q;

endmodule
